// File: rtl/cpu6_irq_ctrl.sv
// cpu6 machine-mode interrupt controller.
// NUM_IRQ prioritised sources (lowest index wins), per-channel enables,
// direct or vectored mtvec dispatch, and the drain/redirect/mepc/mcause
// interrupt-entry sequence held until mret.
// Optional build macro CPU6_IRQ_EDGE_EN: channels become rising-edge
// triggered with sticky pending bits cleared when claimed; otherwise
// pending is a one-cycle registered copy of the source lines.

module cpu6_irq_chan (
    input  logic clk,
    input  logic reset,
    input  logic src,
`ifdef CPU6_IRQ_EDGE_EN
    input  logic claim,
`endif
    output logic pend
);

`ifdef CPU6_IRQ_EDGE_EN
    logic prev;

    // Sticky pending on a rising edge; a fresh edge beats a same-cycle claim.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= 1'b0;
            pend <= 1'b0;
        end else begin
            prev <= src;
            pend <= (src & ~prev) | (pend & ~claim);
        end
    end
`else
    // Level mode: pending mirrors the source with one cycle of latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend <= 1'b0;
        else        pend <= src;
    end
`endif

endmodule

module cpu6_irq_ctrl #(
    parameter int NUM_IRQ    = 4,
    parameter int XLEN       = 32,
    parameter int CAUSE_BASE = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               mstatus_mie,
    input  logic               sync_excp,
    input  logic [XLEN-1:0]    pc_retire,
    input  logic [XLEN-1:0]    csr_mtvec,
    input  logic               drain_ack,
    input  logic               mret,
    output logic               drain_req,
    output logic               inject_nop,
    output logic               flush_pc_ena,
    output logic [XLEN-1:0]    flush_pc,
    output logic               mepc_ena,
    output logic [XLEN-1:0]    mepc,
    output logic               mcause_ena,
    output logic [XLEN-1:0]    mcause,
    output logic               irq_active,
    output logic [NUM_IRQ-1:0] pending
);

    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, TRAP, HANDLER} state_t;

    state_t            state, state_nxt;
    logic [NUM_IRQ-1:0] elig;
    logic [IW-1:0]     win_idx, idx_q;
    logic              win_vld;
    logic              take;
    logic [XLEN-1:0]   pc_q, mepc_q, mcause_q;
    logic [XLEN-1:0]   cause_val, trap_cause, tvec_base;

    // Per-channel pending state.
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
        cpu6_irq_chan u_chan (
            .clk   (clk),
            .reset (reset),
            .src   (irq_src[i]),
`ifdef CPU6_IRQ_EDGE_EN
            .claim ((state == TRAP) && (idx_q == IW'(i))),
`endif
            .pend  (pending[i])
        );
    end

    assign elig = pending & irq_en;

    // Fixed priority: scan from the top so the lowest eligible index wins.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_idx = IW'(i);
                win_vld = 1'b1;
            end
        end
    end

    // A pending synchronous exception wins; the interrupt is retried later.
    assign take = mstatus_mie && win_vld && !sync_excp;

    assign cause_val  = XLEN'(CAUSE_BASE) + XLEN'(idx_q);
    assign trap_cause = {1'b1, cause_val[XLEN-2:0]};
    assign tvec_base  = {csr_mtvec[XLEN-1:2], 2'b00};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Trap is committed once taken: winner and resume PC are latched here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            pc_q  <= '0;
        end else if (state == IDLE && take) begin
            idx_q <= win_idx;
            pc_q  <= pc_retire;
        end
    end

    // mepc/mcause outputs keep the last written values between traps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mepc_q   <= '0;
            mcause_q <= '0;
        end else if (state == TRAP) begin
            mepc_q   <= pc_q;
            mcause_q <= trap_cause;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt    = state;
        drain_req    = 1'b0;
        inject_nop   = 1'b0;
        flush_pc_ena = 1'b0;
        flush_pc     = '0;
        mepc_ena     = 1'b0;
        mepc         = mepc_q;
        mcause_ena   = 1'b0;
        mcause       = mcause_q;
        irq_active   = 1'b0;
        case (state)
            IDLE: begin
                if (take) state_nxt = DRAIN;
            end
            DRAIN: begin
                drain_req  = 1'b1;
                inject_nop = 1'b1;
                if (drain_ack) state_nxt = TRAP;
            end
            TRAP: begin
                drain_req    = 1'b1;
                flush_pc_ena = 1'b1;
                mepc_ena     = 1'b1;
                mcause_ena   = 1'b1;
                mepc         = pc_q;
                mcause       = trap_cause;
                flush_pc     = (csr_mtvec[1:0] == 2'b01) ? tvec_base + (cause_val << 2)
                                                         : tvec_base;
                state_nxt    = HANDLER;
            end
            HANDLER: begin
                irq_active = 1'b1;
                if (mret) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu6_irq_ctrl.sv
// Randomised bench for cpu6_irq_ctrl with a cycle-level reference model
// built from the trap-entry rules, plus directed scenarios.
module tb_cpu6_irq_ctrl;
    localparam int N  = 4;
    localparam int XL = 32;
    localparam int CB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_src, irq_en, pending;
    logic          mstatus_mie, sync_excp, drain_ack, mret;
    logic [XL-1:0] pc_retire, csr_mtvec;
    logic          drain_req, inject_nop, flush_pc_ena, mepc_ena, mcause_ena, irq_active;
    logic [XL-1:0] flush_pc, mepc, mcause;

    cpu6_irq_ctrl #(.NUM_IRQ(N), .XLEN(XL), .CAUSE_BASE(CB)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src), .irq_en(irq_en),
        .mstatus_mie(mstatus_mie), .sync_excp(sync_excp), .pc_retire(pc_retire),
        .csr_mtvec(csr_mtvec), .drain_ack(drain_ack), .mret(mret),
        .drain_req(drain_req), .inject_nop(inject_nop), .flush_pc_ena(flush_pc_ena),
        .flush_pc(flush_pc), .mepc_ena(mepc_ena), .mepc(mepc), .mcause_ena(mcause_ena),
        .mcause(mcause), .irq_active(irq_active), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 draining, 2 trap-entry cycle, 3 in handler.
    int        m_phase;
    bit [N-1:0] m_pend, m_prev;
    int        m_idx;
    bit [31:0] m_pc, m_mepc, m_mcause;

    bit        dir_on;
    bit [31:0] dir_flush, dir_mcause, dir_mepc;
    int        dir_hits;

    // One clock: check outputs at negedge against the model, then advance it.
    task automatic step();
        bit [31:0] cause, base, ef;
        bit [N-1:0] el, np, clr;
        int w;
        @(negedge clk);
        if (!reset) begin
            m_phase = 0; m_pend = '0; m_prev = '0; m_idx = 0;
            m_pc = 0; m_mepc = 0; m_mcause = 0;
        end
        cause = CB + m_idx;
        base  = csr_mtvec & 32'hFFFF_FFFC;
        ef    = (m_phase != 2) ? 32'h0 :
                (csr_mtvec[1:0] == 2'b01) ? base + 4 * cause : base;
        chk("drain_req",    32'(drain_req),    32'(m_phase == 1 || m_phase == 2));
        chk("inject_nop",   32'(inject_nop),   32'(m_phase == 1));
        chk("flush_pc_ena", 32'(flush_pc_ena), 32'(m_phase == 2));
        chk("mepc_ena",     32'(mepc_ena),     32'(m_phase == 2));
        chk("mcause_ena",   32'(mcause_ena),   32'(m_phase == 2));
        chk("irq_active",   32'(irq_active),   32'(m_phase == 3));
        chk("pending",      32'(pending),      32'(m_pend));
        chk("flush_pc",     flush_pc,          ef);
        chk("mepc",         mepc,   (m_phase == 2) ? m_pc : m_mepc);
        chk("mcause",       mcause, (m_phase == 2) ? (32'h8000_0000 | cause) : m_mcause);
        if (dir_on && m_phase == 2) begin
            dir_hits++;
            chk("dir_flush",  flush_pc, dir_flush);
            chk("dir_mcause", mcause,   dir_mcause);
            chk("dir_mepc",   mepc,     dir_mepc);
        end
        if (reset) begin
            el = m_pend & irq_en;
            w = -1;
            for (int i = N - 1; i >= 0; i--) if (el[i]) w = i;
`ifdef CPU6_IRQ_EDGE_EN
            clr = (m_phase == 2) ? (N'(1) << m_idx) : '0;
            np = (irq_src & ~m_prev) | (m_pend & ~clr);
            m_prev = irq_src;
`else
            clr = '0;
            np = irq_src | clr;
`endif
            case (m_phase)
                0: if (mstatus_mie && w >= 0 && !sync_excp) begin
                       m_phase = 1; m_idx = w; m_pc = pc_retire;
                   end
                1: if (drain_ack) m_phase = 2;
                2: begin m_mepc = m_pc; m_mcause = 32'h8000_0000 | cause; m_phase = 3; end
                default: if (mret) m_phase = 0;
            endcase
            m_pend = np;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        irq_src = '0; irq_en = '0; mstatus_mie = 0; sync_excp = 0;
        drain_ack = 0; mret = 0; pc_retire = '0; csr_mtvec = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        dir_on = 0; dir_hits = 0;
        #1;
        do_reset();
        step();

        // Priority + direct mode; source drops during DRAIN; nested request held.
        dir_on = 1; dir_hits = 0;
        dir_flush = 32'h100; dir_mcause = 32'h8000_0011; dir_mepc = 32'h80;
        irq_src = 4'b1010; irq_en = 4'hF; mstatus_mie = 1;
        csr_mtvec = 32'h100; pc_retire = 32'h80;
        step();
        step();
        irq_src = '0; drain_ack = 1; pc_retire = 32'h999;
        step();
        step();
        drain_ack = 0; irq_src = 4'b0001;
        step();
        step();
        chk("hold_active", 32'(irq_active), 32'd1);
        mret = 1;
        step();
        mret = 0;
        chk("mret_idle", 32'(irq_active), 32'd0);
        dir_mcause = 32'h8000_0010; dir_mepc = 32'h999;
        step();
        drain_ack = 1;
        step();
        step();
        step();
        chk("t1_traps", 32'(dir_hits), 32'd2);

        // Vectored mode, channel 2.
        do_reset();
        dir_hits = 0;
        dir_flush = 32'h248; dir_mcause = 32'h8000_0012; dir_mepc = 32'h1234;
        irq_src = 4'b0100; irq_en = 4'hF; mstatus_mie = 1;
        csr_mtvec = 32'h201; pc_retire = 32'h1234;
        step();
        step();
        drain_ack = 1;
        step();
        step();
        step();
        chk("t2_traps", 32'(dir_hits), 32'd1);
        dir_on = 0;

        // Blocking: mie off, sync exception, channel disabled.
        do_reset();
        irq_src = 4'b0001; irq_en = 4'hF; mstatus_mie = 0; drain_ack = 1;
        step(); step(); step();
        chk("mie_block", 32'(drain_req), 32'd0);
        mstatus_mie = 1; sync_excp = 1;
        step(); step();
        chk("excp_block", 32'(drain_req), 32'd0);
        sync_excp = 0; irq_en = '0;
        step(); step();
        chk("en_block", 32'(drain_req), 32'd0);
        chk("en_pend", 32'(pending[0]), 32'd1);

        // Reset while draining.
        irq_en = 4'hF; drain_ack = 0;
        step(); step();
        chk("in_drain", 32'(drain_req), 32'd1);
        reset = 0;
        step();
        chk("rst_drain", 32'(drain_req), 32'd0);
        step();
        reset = 1; mstatus_mie = 0;
        step();
        chk("rst_after", 32'(inject_nop), 32'd0);

`ifdef CPU6_IRQ_EDGE_EN
        // Edge mode: a short pulse stays pending until claimed.
        do_reset();
        irq_en = 4'hF; mstatus_mie = 0; irq_src = 4'b0001;
        step();
        irq_src = '0;
        step(); step();
        chk("edge_hold", 32'(pending[0]), 32'd1);
        mstatus_mie = 1;
        step();
        drain_ack = 1;
        step(); step(); step();
        chk("edge_clr", 32'(pending[0]), 32'd0);
`endif

        // Randomised traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 99) != 0);
            irq_src     = N'($urandom());
            irq_en      = ($urandom_range(0, 3) != 0) ? 4'hF : N'($urandom());
            mstatus_mie = ($urandom_range(0, 3) != 0);
            sync_excp   = ($urandom_range(0, 4) == 0);
            drain_ack   = ($urandom_range(0, 4) < 2);
            mret        = ($urandom_range(0, 4) == 0);
            pc_retire   = $urandom() & 32'hFFFF_FFFC;
            csr_mtvec   = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
